change_dispenser: RTL and testbench

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/change_dispenser.sv | 169 ++++++++++++++++
 tb/tb_change_dispenser.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Nickel refund dispenser: solenoid pulse/gap sequencing with a sensor jam timeout.
// Inventory tracking is compiled in with CHANGE_DISPENSER_TUBE_COUNT_EN.
module change_dispenser #(
  parameter int PULSE_CYCLES   = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [3:0] req_count,
  output logic       req_ready,
  input  logic       coin_seen,
`ifdef CHANGE_DISPENSER_TUBE_COUNT_EN
  input  logic       load_valid,
  input  logic [7:0] load_count,
  output logic [7:0] tube_level,
`endif
  output logic       eject,
  output logic       busy,
  output logic [3:0] remaining,
  output logic       done,
  output logic       reject,
  output logic       fault
);

  localparam int MAX_A =
    (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int MAX_C =
    (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] P_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] G_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    PULSE,
    WAIT_SENSE,
    GAP,
    FAULT
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [3:0]    rem_n;
  logic          done_n;
  logic          reject_n;
  logic          take_coin;
  logic          too_few;

`ifdef CHANGE_DISPENSER_TUBE_COUNT_EN
  logic [7:0] level_n;
  logic [9:0] sum;

  assign too_few = {4'd0, req_count} > tube_level;

  // Load and a counted coin may land together; clamp both ends.
  always_comb begin
    sum = {2'b00, tube_level};
    if (load_valid) begin
      sum = sum + {2'b00, load_count};
    end
    if (take_coin && (sum != 10'd0)) begin
      sum = sum - 10'd1;
    end
    level_n = (sum > 10'd255) ? 8'hff : sum[7:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tube_level <= 8'd0;
    end else begin
      tube_level <= level_n;
    end
  end
`else
  assign too_few = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      remaining <= 4'd0;
      done      <= 1'b0;
      reject    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      remaining <= rem_n;
      done      <= done_n;
      reject    <= reject_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    rem_n     = remaining;
    done_n    = 1'b0;
    reject_n  = 1'b0;
    take_coin = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_count == 4'd0) begin
            done_n = 1'b1;
          end else if (too_few) begin
            reject_n = 1'b1;
          end else begin
            rem_n   = req_count;
            cnt_n   = '0;
            state_n = PULSE;
          end
        end
      end
      PULSE: begin
        if (cnt == P_LAST) begin
          cnt_n   = '0;
          state_n = WAIT_SENSE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      WAIT_SENSE: begin
        // Leaving on the first sensed coin gives one decrement per pulse.
        if (coin_seen) begin
          take_coin = 1'b1;
          cnt_n     = '0;
          rem_n     = (remaining != 4'd0) ? remaining - 4'd1 : 4'd0;
          if (remaining <= 4'd1) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = GAP;
          end
        end else if (cnt == T_LAST) begin
          state_n = FAULT;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      GAP: begin
        if (cnt == G_LAST) begin
          cnt_n   = '0;
          state_n = PULSE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      FAULT: begin
        state_n = FAULT;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign eject     = (state == PULSE);
  assign fault     = (state == FAULT);

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: timestamp-based reference model checked every
// cycle, plus directed scenarios with literal expected waveforms.
`timescale 1ns/1ps
module tb_change_dispenser;

  localparam int P = 4;
  localparam int G = 2;
  localparam int T = 16;
`ifdef CHANGE_DISPENSER_TUBE_COUNT_EN
  localparam bit TUBE = 1'b1;
`else
  localparam bit TUBE = 1'b0;
`endif

  logic       clock;
  logic       reset;
  logic       req_valid;
  logic [3:0] req_count;
  logic       req_ready;
  logic       coin_seen;
  logic       eject;
  logic       busy;
  logic [3:0] remaining;
  logic       done;
  logic       reject;
  logic       fault;
`ifdef CHANGE_DISPENSER_TUBE_COUNT_EN
  logic       load_valid;
  logic [7:0] load_count;
  logic [7:0] tube_level;
`endif

  int checks;
  int errors;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  change_dispenser #(
    .PULSE_CYCLES(P),
    .GAP_CYCLES(G),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req_valid(req_valid),
    .req_count(req_count),
    .req_ready(req_ready),
    .coin_seen(coin_seen),
`ifdef CHANGE_DISPENSER_TUBE_COUNT_EN
    .load_valid(load_valid),
    .load_count(load_count),
    .tube_level(tube_level),
`endif
    .eject(eject),
    .busy(busy),
    .remaining(remaining),
    .done(done),
    .reject(reject),
    .fault(fault)
  );

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", n, act, exp);
    end
  endtask

  // Reference model: a dispense is a series of pulses timestamped by the
  // cycle they start in; the sense window follows each pulse.
  localparam int M_IDLE = 0;
  localparam int M_DISP = 1;
  localparam int M_FAULT = 2;

  int m_mode;
  int m_rem;
  int m_lvl;
  int pstart;
  int cyc;
  bit m_done;
  bit m_rej;
  bit live;

  initial begin
    m_mode = M_IDLE;
    m_rem = 0;
    m_lvl = 0;
    pstart = 0;
    cyc = 0;
    m_done = 0;
    m_rej = 0;
    live = 0;
  end

  always @(posedge clock) begin : model
    int c;
    int ws;
    int we;
    int dec;
    c = cyc;
    dec = 0;
    if (reset) begin
      m_mode = M_IDLE;
      m_rem = 0;
      m_done = 0;
      m_rej = 0;
      m_lvl = 0;
    end else begin
      m_done = 0;
      m_rej = 0;
      if (m_mode == M_IDLE) begin
        if (req_valid) begin
          if (req_count == 0) m_done = 1;
          else if (TUBE && int'(req_count) > m_lvl) m_rej = 1;
          else begin
            m_mode = M_DISP;
            m_rem = int'(req_count);
            pstart = c + 1;
          end
        end
      end else if (m_mode == M_DISP) begin
        ws = pstart + P;
        we = ws + T - 1;
        if (c >= ws && c <= we) begin
          if (coin_seen) begin
            dec = 1;
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
              m_mode = M_IDLE;
              m_done = 1;
            end else begin
              pstart = c + 1 + G;
            end
          end else if (c == we) begin
            m_mode = M_FAULT;
          end
        end
      end
`ifdef CHANGE_DISPENSER_TUBE_COUNT_EN
      if (load_valid) m_lvl = m_lvl + int'(load_count);
      m_lvl = m_lvl - dec;
      if (m_lvl < 0) m_lvl = 0;
      if (m_lvl > 255) m_lvl = 255;
`endif
    end
    cyc = c + 1;
    live = 1;
  end

  always @(negedge clock) begin
    bit ej;
    if (live) begin
      ej = (m_mode == M_DISP) && (cyc >= pstart) && (cyc < pstart + P);
      chk("eject", int'(eject), int'(ej));
      chk("busy", int'(busy), int'(m_mode != M_IDLE));
      chk("req_ready", int'(req_ready), int'(m_mode == M_IDLE));
      chk("fault", int'(fault), int'(m_mode == M_FAULT));
      chk("remaining", int'(remaining), m_rem);
      chk("done", int'(done), int'(m_done));
      chk("reject", int'(reject), int'(m_rej));
      chk("done_reject_excl", int'(done && reject), 0);
`ifdef CHANGE_DISPENSER_TUBE_COUNT_EN
      chk("tube_level", int'(tube_level), m_lvl);
`endif
    end
  end

  logic [31:0] ej_m;
  logic [31:0] dn_m;
  logic [31:0] bz_m;
  logic [31:0] rd_m;
  logic [31:0] fl_m;
  logic [31:0] rj_m;
  int          rm[32];
  int          lv[32];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    ej_m = '0;
    dn_m = '0;
    bz_m = '0;
    rd_m = '0;
    fl_m = '0;
    rj_m = '0;
  endtask

  task automatic rec(input int k);
    @(negedge clock);
    ej_m[k] = eject;
    dn_m[k] = done;
    bz_m[k] = busy;
    rd_m[k] = req_ready;
    fl_m[k] = fault;
    rj_m[k] = reject;
    rm[k] = int'(remaining);
`ifdef CHANGE_DISPENSER_TUBE_COUNT_EN
    lv[k] = int'(tube_level);
`else
    lv[k] = 0;
`endif
    tick();
  endtask

  task automatic idle_in();
    req_valid = 1'b0;
    req_count = 4'd0;
    coin_seen = 1'b0;
`ifdef CHANGE_DISPENSER_TUBE_COUNT_EN
    load_valid = 1'b0;
    load_count = 8'd0;
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    idle_in();
    tick();
    tick();
    reset = 1'b0;
`ifdef CHANGE_DISPENSER_TUBE_COUNT_EN
    load_valid = 1'b1;
    load_count = 8'd200;
    tick();
    load_valid = 1'b0;
`endif

    // two nickels, coin one cycle after each pulse
    clr();
    for (int k = 0; k < 16; k++) begin
      req_valid = (k == 0);
      req_count = 4'd2;
      coin_seen = (k == 5 || k == 12);
      rec(k);
    end
    idle_in();
    chk("t1_eject_mask", int'(ej_m[15:0]), 32'h0f1e);
    chk("t1_done_mask", int'(dn_m[15:0]), 32'h2000);
    chk("t1_busy_mask", int'(bz_m[15:0]), 32'h1ffe);
    chk("t1_rem_off3", rm[3], 2);
    chk("t1_rem_off7", rm[7], 1);
    chk("t1_rem_off13", rm[13], 0);

    // zero-count request
    clr();
    for (int k = 0; k < 4; k++) begin
      req_valid = (k == 0);
      req_count = 4'd0;
      rec(k);
    end
    idle_in();
    chk("t2_done_mask", int'(dn_m[3:0]), 2);
    chk("t2_eject_mask", int'(ej_m[3:0]), 0);
    chk("t2_busy_mask", int'(bz_m[3:0]), 0);

    // jam: no coin ever sensed
    clr();
    for (int k = 0; k < 25; k++) begin
      req_valid = (k == 0 || k == 22);
      req_count = 4'd3;
      rec(k);
    end
    idle_in();
    chk("t3_eject_mask", int'(ej_m[24:0]), 32'h1e);
    chk("t3_fault_mask", int'(fl_m[24:0]), 32'h01e00000);
    chk("t3_ready_end", int'(rd_m[24]), 0);
    chk("t3_rem_frozen", rm[24], 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("t3_rst_eject", int'(eject), 0);
    chk("t3_rst_busy", int'(busy), 0);
    chk("t3_rst_fault", int'(fault), 0);
    chk("t3_rst_ready", int'(req_ready), 1);
    chk("t3_rst_rem", int'(remaining), 0);
    chk("t3_rst_done", int'(done), 0);
`ifdef CHANGE_DISPENSER_TUBE_COUNT_EN
    chk("t3_rst_level", int'(tube_level), 0);
    tick();
    load_valid = 1'b1;
    load_count = 8'd100;
    tick();
    load_valid = 1'b0;
`else
    tick();
`endif

    // reset in third pulse cycle
    clr();
    for (int k = 0; k < 6; k++) begin
      req_valid = (k == 0);
      req_count = 4'd5;
      reset = (k == 3);
      rec(k);
    end
    idle_in();
    chk("t4_eject_mask", int'(ej_m[5:0]), 32'h0e);
    chk("t4_busy_mask", int'(bz_m[5:0]), 32'h0e);
    chk("t4_rem_off4", rm[4], 0);
`ifdef CHANGE_DISPENSER_TUBE_COUNT_EN
    load_valid = 1'b1;
    load_count = 8'd100;
    tick();
    load_valid = 1'b0;
`endif

    // request held high, stray coins in pulse and gap
    clr();
    for (int k = 0; k < 15; k++) begin
      req_valid = (k < 13);
      req_count = 4'd2;
      coin_seen = (k == 2 || k == 5 || k == 6 || k == 7 || k == 12);
      rec(k);
    end
    idle_in();
    chk("t5_ready_mask", int'(rd_m[14:0]), 32'h6001);
    chk("t5_eject_mask", int'(ej_m[14:0]), 32'h0f1e);
    chk("t5_rem_gap", rm[7], 1);
    chk("t5_done_off13", int'(dn_m[13]), 1);

`ifdef CHANGE_DISPENSER_TUBE_COUNT_EN
    // inventory: reject, drain to zero, saturate
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clr();
    for (int k = 0; k < 21; k++) begin
      load_valid = (k == 0 || k == 17 || k == 18);
      load_count = (k == 0) ? 8'd2 : 8'd250;
      req_valid = (k == 1 || k == 3);
      req_count = (k == 1) ? 4'd3 : 4'd2;
      coin_seen = (k == 8 || k == 15);
      rec(k);
    end
    idle_in();
    chk("t7_reject_mask", int'(rj_m[20:0]), 32'h4);
    chk("t7_eject_mask", int'(ej_m[20:0]), 32'h78f0);
    chk("t7_done_off16", int'(dn_m[16]), 1);
    chk("t7_level_off1", lv[1], 2);
    chk("t7_level_off16", lv[16], 0);
    chk("t7_level_off18", lv[18], 250);
    chk("t7_level_off19", lv[19], 255);
`endif

    // mixed traffic against the model
    for (int k = 0; k < 400; k++) begin
      reset = fault;
      req_valid = ($urandom_range(0, 4) == 0);
      req_count = 4'($urandom_range(0, 15));
      coin_seen = ($urandom_range(0, 2) == 0);
`ifdef CHANGE_DISPENSER_TUBE_COUNT_EN
      load_valid = ($urandom_range(0, 9) == 0);
      load_count = 8'($urandom_range(0, 40));
`endif
      tick();
    end
    reset = 1'b0;
    idle_in();
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
